// File: rtl/tone_voice_scheduler.sv
// Time-multiplexed sawtooth voice generator and stereo mixer.
// Define TONE_PAN_EN to add per-voice left/right pan.
module tone_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int VW         = $clog2(NUM_VOICES)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_sample_req,
    input  logic            i_cfg_we,
    input  logic [VW-1:0]   i_cfg_addr,
    input  logic [15:0]     i_cfg_fcw,
    input  logic            i_cfg_en,
`ifdef TONE_PAN_EN
    input  logic [1:0]      i_cfg_pan,
`endif
    input  logic            i_ovr_clr,
    output logic [31:0]     o_sample,
    output logic            o_sample_valid,
    output logic            o_busy,
    output logic            o_overrun
);

    localparam int SW = 16 + VW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [VW-1:0]         r_idx;
    logic [15:0]           r_phase [NUM_VOICES];
    logic [15:0]           r_fcw   [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_en;
    logic signed [SW-1:0]  r_sum_l;

    logic                  w_last;
    logic                  w_start;
    logic [15:0]           w_cur_phase;
    logic [15:0]           w_cur_fcw;
    logic                  w_cur_en;
    logic [15:0]           w_wave;
    logic signed [SW-1:0]  w_wave_ext;
    logic                  w_take_l;
    logic signed [SW-1:0]  w_sum_l_nxt;
    logic [15:0]           w_out_l;
    logic [15:0]           w_out_r;

`ifdef TONE_PAN_EN
    logic [1:0]            r_pan [NUM_VOICES];
    logic signed [SW-1:0]  r_sum_r;
    logic                  w_take_r;
    logic signed [SW-1:0]  w_sum_r_nxt;
`endif

    assign w_last      = (r_idx == VW'(NUM_VOICES - 1));
    assign w_start     = (r_state == S_IDLE) && i_sample_req;
    assign w_cur_phase = r_phase[r_idx];
    assign w_cur_fcw   = r_fcw[r_idx];
    assign w_cur_en    = r_en[r_idx];

    // Flipping the MSB turns the unsigned phase ramp into a two's-complement saw.
    assign w_wave      = w_cur_phase ^ 16'h8000;
    assign w_wave_ext  = {{VW{w_wave[15]}}, w_wave};

`ifdef TONE_PAN_EN
    assign w_take_l    = w_cur_en && r_pan[r_idx][1];
    assign w_take_r    = w_cur_en && r_pan[r_idx][0];
    assign w_sum_l_nxt = r_sum_l + (w_take_l ? w_wave_ext : '0);
    assign w_sum_r_nxt = r_sum_r + (w_take_r ? w_wave_ext : '0);
    assign w_out_l     = 16'(w_sum_l_nxt >>> VW);
    assign w_out_r     = 16'(w_sum_r_nxt >>> VW);
`else
    assign w_take_l    = w_cur_en;
    assign w_sum_l_nxt = r_sum_l + (w_take_l ? w_wave_ext : '0);
    assign w_out_l     = 16'(w_sum_l_nxt >>> VW);
    assign w_out_r     = w_out_l;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        o_busy         = 1'b0;
        o_sample_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_sample_req) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_busy         = 1'b1;
                o_sample_valid = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sweep datapath: the final sum is folded straight into o_sample so the
    // result is already visible in the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx    <= '0;
            r_sum_l  <= '0;
`ifdef TONE_PAN_EN
            r_sum_r  <= '0;
`endif
            o_sample <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v] <= '0;
            end
        end else if (w_start) begin
            r_idx    <= '0;
            r_sum_l  <= '0;
`ifdef TONE_PAN_EN
            r_sum_r  <= '0;
`endif
        end else if (r_state == S_RUN) begin
            r_idx   <= r_idx + VW'(1);
            r_sum_l <= w_sum_l_nxt;
`ifdef TONE_PAN_EN
            r_sum_r <= w_sum_r_nxt;
`endif
            if (w_cur_en) begin
                r_phase[r_idx] <= w_cur_phase + w_cur_fcw;
            end
            if (w_last) begin
                o_sample <= {w_out_l, w_out_r};
            end
        end
    end

    // Config registers; the sweep reads the pre-write value in the write cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_fcw[v] <= '0;
`ifdef TONE_PAN_EN
                r_pan[v] <= 2'b11;
`endif
            end
        end else if (i_cfg_we) begin
            r_fcw[i_cfg_addr] <= i_cfg_fcw;
            r_en[i_cfg_addr]  <= i_cfg_en;
`ifdef TONE_PAN_EN
            r_pan[i_cfg_addr] <= i_cfg_pan;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overrun <= 1'b0;
        end else if (i_sample_req && (r_state != S_IDLE)) begin
            o_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            o_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tone_voice_scheduler.sv
// Bench for tone_voice_scheduler: timeline model checked every cycle plus
// hand-computed literal samples and timing points.
module tb_tone_voice_scheduler;

    localparam int N  = 4;
    localparam int VW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  addr = '0;
    logic [15:0] fcw  = '0;
    logic        en   = 1'b0;
    logic [1:0]  pan  = 2'b11;

    logic [31:0] o_sample;
    logic        o_valid;
    logic        o_busy;
    logic        o_ovr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tone_voice_scheduler #(.NUM_VOICES(N)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sample_req   (req),
        .i_cfg_we       (we),
        .i_cfg_addr     (addr),
        .i_cfg_fcw      (fcw),
        .i_cfg_en       (en),
`ifdef TONE_PAN_EN
        .i_cfg_pan      (pan),
`endif
        .i_ovr_clr      (clr),
        .o_sample       (o_sample),
        .o_sample_valid (o_valid),
        .o_busy         (o_busy),
        .o_overrun      (o_ovr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Timeline model: m_pos=-1 idle, 0..N-1 voice being processed, N result cycle.
    int          m_phase [N];
    int          m_fcw   [N];
    bit          m_en    [N];
    bit [1:0]    m_pan   [N];
    int          m_pos   = -1;
    int          m_suml  = 0;
    int          m_sumr  = 0;
    logic [31:0] m_sample = '0;
    bit          m_ovr   = 1'b0;
    bit          m_live  = 1'b0;

    always @(posedge clk) begin
        int w;
        if (rst) begin
            for (int v = 0; v < N; v++) begin
                m_phase[v] = 0; m_fcw[v] = 0; m_en[v] = 0; m_pan[v] = 2'b11;
            end
            m_pos = -1; m_sample = '0; m_ovr = 0;
        end else begin
            if (req && m_pos != -1) m_ovr = 1;
            else if (clr) m_ovr = 0;
            if (m_pos == -1) begin
                if (req) begin m_pos = 0; m_suml = 0; m_sumr = 0; end
            end else if (m_pos < N) begin
                if (m_en[m_pos]) begin
                    w = m_phase[m_pos] - 32768;
                    if (m_pan[m_pos][1]) m_suml += w;
                    if (m_pan[m_pos][0]) m_sumr += w;
                    m_phase[m_pos] = (m_phase[m_pos] + m_fcw[m_pos]) % 65536;
                end
                m_pos++;
                if (m_pos == N) m_sample = {16'(m_suml >>> VW), 16'(m_sumr >>> VW)};
            end else begin
                m_pos = -1;
            end
            if (we) begin
                m_fcw[addr] = fcw;
                m_en[addr]  = en;
`ifdef TONE_PAN_EN
                m_pan[addr] = pan;
`else
                m_pan[addr] = 2'b11;
`endif
            end
        end
        m_live = 1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy",    o_busy,   (m_pos != -1));
            chk("valid",   o_valid,  (m_pos == N));
            chk("overrun", o_ovr,    m_ovr);
            chk("sample",  o_sample, m_sample);
        end
    end

    task automatic tick();
        @(negedge clk);
        req = 0; we = 0; clr = 0;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] f, input logic e, input logic [1:0] p);
        tick();
        we = 1; addr = a; fcw = f; en = e; pan = p;
    endtask

    task automatic do_reset();
        tick(); rst = 1;
        tick(); tick(); rst = 0;
    endtask

    task automatic req_wait(input string nm, input bit lit, input logic [31:0] exp);
        bit got = 0;
        tick(); req = 1;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (o_valid) begin
                got = 1;
                chk({nm, "_lat"}, k, N);
                if (lit) chk(nm, o_sample, exp);
            end
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: got no valid expected valid within 20 cycles", nm);
        end
    endtask

    initial begin
        int vcnt;
        bit got;
        repeat (3) @(negedge clk);
        chk("rst_sample", o_sample, 32'h0);
        chk("rst_valid",  o_valid,  0);
        chk("rst_busy",   o_busy,   0);
        chk("rst_ovr",    o_ovr,    0);
        rst = 0;

        // single saw voice and its 16-step wrap
        cfg(2'd0, 16'h1000, 1, 2'b11);
        req_wait("saw1", 1, 32'hE000E000);
        req_wait("saw2", 1, 32'hE400E400);
        for (int k = 3; k <= 16; k++) req_wait($sformatf("saw%0d", k), 0, 0);
        req_wait("saw_wrap", 1, 32'hE000E000);

        // all voices at full negative, fcw=0
        do_reset();
        for (int v = 0; v < N; v++) cfg(2'(v), 16'h0, 1, 2'b11);
        req_wait("fcw0_a", 1, 32'h80008000);
        req_wait("fcw0_b", 1, 32'h80008000);

        // busy/valid timing, ignored request, overrun
        tick(); req = 1;
        vcnt = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 2) req = 1;
            chk($sformatf("t_busy%0d", k),  o_busy,  (k <= 5));
            chk($sformatf("t_valid%0d", k), o_valid, (k == 5));
            if (k >= 3) chk($sformatf("t_ovr%0d", k), o_ovr, 1);
            if (k == 5) chk("t_sample", o_sample, 32'h80008000);
            vcnt += int'(o_valid);
        end
        chk("t_one_pulse", vcnt, 1);
        tick(); clr = 1;
        tick();
        chk("ovr_cleared", o_ovr, 0);
        tick(); req = 1;
        tick(); req = 1; clr = 1;
        tick();
        chk("ovr_set_wins", o_ovr, 1);
        repeat (6) tick();
        clr = 1;
        tick();
        chk("ovr_cleared2", o_ovr, 0);

        // reset in the middle of a sweep
        cfg(2'd2, 16'h0777, 1, 2'b11);
        req_wait("pre_abort", 0, 0);
        tick(); req = 1;
        tick();
        tick(); rst = 1;
        tick(); rst = 0;
        chk("abort_sample", o_sample, 32'h0);
        chk("abort_busy",   o_busy,   0);
        vcnt = 0;
        for (int k = 0; k < 6; k++) begin tick(); vcnt += int'(o_valid); end
        chk("abort_no_valid", vcnt, 0);
        cfg(2'd0, 16'h1000, 1, 2'b11);
        cfg(2'd2, 16'h0000, 1, 2'b11);
        req_wait("abort_phase0", 1, 32'hC000C000);

        // fcw write coinciding with that voice's processing cycle
        do_reset();
        cfg(2'd1, 16'h1000, 1, 2'b11);
        tick(); req = 1;
        tick();
        tick(); we = 1; addr = 2'd1; fcw = 16'h2000; en = 1; pan = 2'b11;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (o_valid) begin got = 1; chk("mid1", o_sample, 32'hE000E000); end
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL mid1_timeout: got no valid expected valid within 20 cycles");
        end
        req_wait("mid2", 1, 32'hE400E400);
        req_wait("mid3", 1, 32'hEC00EC00);

        // mixed voices, model-checked, including an early-voice write mid-sweep
        do_reset();
        cfg(2'd0, 16'h0123, 1, 2'b11);
        cfg(2'd1, 16'h4567, 1, 2'b11);
        cfg(2'd2, 16'h89AB, 1, 2'b11);
        cfg(2'd3, 16'hCDEF, 0, 2'b11);
        for (int k = 0; k < 5; k++) req_wait($sformatf("mix%0d", k), 0, 0);
        tick(); req = 1;
        tick(); we = 1; addr = 2'd3; fcw = 16'hCDEF; en = 1; pan = 2'b11;
        repeat (6) tick();
        for (int k = 0; k < 4; k++) req_wait($sformatf("mixb%0d", k), 0, 0);

`ifdef TONE_PAN_EN
        do_reset();
        cfg(2'd0, 16'h0000, 1, 2'b10);
        req_wait("pan_left", 1, 32'hE0000000);
        cfg(2'd1, 16'h0000, 1, 2'b01);
        req_wait("pan_both", 1, 32'hE000E000);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tone_voice_scheduler.md
Name: tone_voice_scheduler

Overview:
- Time-multiplexed multi-voice sawtooth tone generator and mixer.
- On each sample request it sweeps one shared phase-accumulator datapath across NUM_VOICES voices, one voice per clock.
- It sums the voices and presents one mixed stereo 32-bit sample, left in the upper half, right in the lower half.
- Sits between the sample-rate request source and the audio output path. It replaces single-tone test generation when several tones are needed.

Parameters:
- NUM_VOICES, 4: voice count. Power of two, 2..16.
- VW, $clog2(NUM_VOICES): derived voice index width. Do not override.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_sample_req  in  1  one-cycle pulse requesting the next sample.
- i_cfg_we  in  1  config write strobe.
- i_cfg_addr  in  VW  voice index to write.
- i_cfg_fcw  in  16  frequency control word for that voice.
- i_cfg_en  in  1  voice enable.
- i_cfg_pan  in  2  {left_en, right_en}. Present only with TONE_PAN_EN.
- i_ovr_clr  in  1  clears o_overrun.
- o_sample  out  32  mixed sample {left[15:0], right[15:0]}.
- o_sample_valid  out  1  one-cycle pulse when o_sample updates.
- o_busy  out  1  high while a sweep is in progress (RUN or DONE).
- o_overrun  out  1  sticky: a request arrived while not IDLE.

Behaviour:
- Reset: all phase accumulators, fcw and en registers are 0; pan is 2'b11 if present. o_sample=0, o_sample_valid=0, o_busy=0, o_overrun=0; FSM goes to IDLE.
- Reset mid-sweep: aborts the sweep, discards the partial sum, emits no valid pulse.
- FSM states IDLE, RUN, DONE:
  - IDLE: on i_sample_req go to RUN; clear voice index to 0 and the accumulating sum to 0.
  - RUN: process voice[idx]; idx increments each cycle; after idx==NUM_VOICES-1 go to DONE.
  - DONE: register o_sample, pulse o_sample_valid for exactly one cycle, return to IDLE.
- Latency: request sampled in IDLE at cycle T. Voices 0..N-1 are processed in cycles T+1..T+N. o_sample and o_sample_valid are visible at cycle T+N+1. Earliest next accepted request is cycle T+N+2.
- o_busy is high for cycles T+1..T+N+1.
- Request while RUN or DONE: ignored, no extra sweep; sets o_overrun.
- o_overrun clears only on i_rst or i_ovr_clr. If set and clear coincide, set wins.
- Per-voice processing:
  - wave = phase ^ 16'h8000, read as signed, i.e. a two's-complement saw. It uses the pre-update phase.
  - If en=1: sum += sign-extended wave; phase <= phase + fcw, with 16-bit modulo wrap and no carry out.
  - If en=0: contributes 0; phase is held.
- Sum width is 16+VW bits, signed, and never overflows.
- Output per channel = sum >>> VW, lower 16 bits. This is an arithmetic shift and the result always fits.
- Config writes:
  - Take effect the cycle after i_cfg_we.
  - Writing fcw does not reset that voice's phase.
  - If a write targets the voice being processed in the same cycle, the old fcw/en are used for that processing.
  - A write to an already-processed voice applies from the next sweep.
  - Writes are accepted in any state.

Optional Feature:
- Macro: TONE_PAN_EN.
- Defined: per-voice 2-bit pan register, written with fcw and en. Left sum includes a voice only if pan[1]; right sum only if pan[0]. The two sums are independent, each 16+VW bits and each shifted by VW. An enabled voice with pan=00 still advances its phase.
- Undefined: i_cfg_pan port and pan storage are absent. One sum feeds both halves, so o_sample[31:16]==o_sample[15:0] always.

Test Plan (NUM_VOICES=4):
- Voice0 fcw=16'h1000, en=1, others disabled; request -> o_sample=32'hE000E000. Second request -> 32'hE400E400. Sixteenth-plus-one request wraps the phase back to 0 -> 32'hE000E000.
- All four voices en=1, fcw=0 -> each request gives 32'h80008000 and phases stay 0.
- Request at cycle 10 -> o_busy high for cycles 11..15; o_sample_valid is a single pulse at 15. Extra request at cycle 12 -> o_overrun=1 and still exactly one valid pulse. i_ovr_clr -> o_overrun=0.
- Assert i_rst at cycle T+2 of a sweep -> no valid pulse; o_sample=0; o_busy=0; all phases 0.
- During a sweep, write voice1 fcw=16'h2000 in the same cycle voice1 is processed -> voice1 phase advances by the old fcw this sweep and by 16'h2000 on the next sweep.
- TONE_PAN_EN: voice0 en=1, pan=2'b10, fcw=0, others disabled -> o_sample=32'hE0000000.
